// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the EX-stage branch path (ALU and branch_resolver).
//   XLEN         : datapath width
//   BT_*         : ALU branch_taken codes (3 bits, codes 4-7 are reserved)
//   ST_*         : branch_resolver state encoding (exposed on its debug port)
//   bt_is_taken  : true for the three redirecting codes
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] BT_NONE   = 3'd0;
    localparam logic [2:0] BT_BRANCH = 3'd1;
    localparam logic [2:0] BT_JAL    = 3'd2;
    localparam logic [2:0] BT_JALR   = 3'd3;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT     = 2'd1;
    localparam logic [1:0] ST_RESOLVE  = 2'd2;
    localparam logic [1:0] ST_REDIRECT = 2'd3;

    function automatic logic bt_is_taken(input logic [2:0] code);
        return (code == BT_BRANCH) || (code == BT_JAL) || (code == BT_JALR);
    endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// -----------------------------------------------------------------------------
// branch_resolver_if
// Redirect handshake between branch_resolver (master) and fetch (slave).
//   redirect_valid : master -> slave, redirect_pc is meaningful
//   redirect_pc    : master -> slave, new fetch address
//   redirect_ack   : slave -> master, fetch accepts redirect_pc
//
// Handshake: the master raises redirect_valid with redirect_pc and holds both
// stable until it samples redirect_ack high on a rising clock edge; valid drops
// in the cycle after that edge. The slave may raise ack in the very cycle valid
// first appears. Ack while valid is low has no effect.
// -----------------------------------------------------------------------------
interface branch_resolver_if
    import cpu_pkg::*;
#(
    parameter int XLEN = cpu_pkg::XLEN
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ack;

    modport master (
        output redirect_valid,
        output redirect_pc,
        input  redirect_ack
    );

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ack
    );
endinterface

// File: rtl/branch_resolver_target_calc.sv
// -----------------------------------------------------------------------------
// branch_target_calc
// Combinational redirect target: pc+imm for branches/JAL, (rs1+imm) with bit 0
// cleared for JALR. Addition wraps at XLEN bits.
//   code_i     : ALU branch_taken code
//   pc_i       : latched PC
//   imm_i      : latched immediate
//   rs1_i      : latched rs1
//   target_o   : computed target
//   taken_o    : code redirects (1/2/3)
//   reserved_o : code is 4-7
//   misalign_o : taken and target bit 1 set (checked after the JALR bit-0 clear)
// -----------------------------------------------------------------------------
module branch_target_calc
    import cpu_pkg::*;
#(
    parameter int XLEN = cpu_pkg::XLEN
) (
    input  logic [2:0]      code_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_i,
    output logic [XLEN-1:0] target_o,
    output logic            taken_o,
    output logic            reserved_o,
    output logic            misalign_o
);
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] sum;

    always_comb begin
        base     = (code_i == BT_JALR) ? rs1_i : pc_i;
        sum      = base + imm_i;
        target_o = sum;
        if (code_i == BT_JALR) begin
            target_o[0] = 1'b0;
        end
        taken_o    = bt_is_taken(code_i);
        reserved_o = code_i[2];
        misalign_o = taken_o & target_o[1];
    end
endmodule

// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
// EX-stage branch resolution. Latches pc/imm/rs1 on tick_idex, waits
// SETTLE_CYCLES for the ALU's registered branch_taken, then either redirects
// fetch (with a flush pulse), raises a misalignment exception, or returns idle.
//   clk, rst_n     : clock, asynchronous active-low reset
//   tick_idex      : ID/EX advance strobe
//   pc, imm, rs1   : operands of the instruction entering EX
//   branch_taken   : ALU resolution code (see cpu_pkg BT_*)
//   busy           : registered, high whenever the state is not IDLE
//   flush          : one-cycle pulse alongside a new redirect
//   misalign_exc   : one-cycle pulse, taken target has bit 1 set
//   misalign_addr  : last misaligned target, held
//   proto_err      : sticky until reset; tick in REDIRECT or reserved code
//   dbg_state_o    : current FSM state (cpu_pkg ST_*)
//   redir          : redirect handshake towards fetch
// SETTLE_CYCLES must be at least 1.
// -----------------------------------------------------------------------------
module branch_resolver
    import cpu_pkg::*;
#(
    parameter int XLEN          = cpu_pkg::XLEN,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_idex,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   rs1,
    input  logic [2:0]        branch_taken,
    output logic              busy,
    output logic              flush,
    output logic              misalign_exc,
    output logic [XLEN-1:0]   misalign_addr,
    output logic              proto_err,
    output logic [1:0]        dbg_state_o,
    branch_resolver_if.master redir
);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] rpc_q, rpc_d;
    logic            flush_q, flush_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] maddr_q, maddr_d;
    logic            perr_q, perr_d;

    logic [XLEN-1:0] target;
    logic            taken;
    logic            reserved;
    logic            misalign;

    branch_target_calc #(.XLEN(XLEN)) u_calc (
        .code_i     (branch_taken),
        .pc_i       (pc_q),
        .imm_i      (imm_q),
        .rs1_i      (rs1_q),
        .target_o   (target),
        .taken_o    (taken),
        .reserved_o (reserved),
        .misalign_o (misalign)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        imm_d   = imm_q;
        rs1_d   = rs1_q;
        valid_d = valid_q;
        rpc_d   = rpc_q;
        flush_d = 1'b0;
        mis_d   = 1'b0;
        maddr_d = maddr_q;
        perr_d  = perr_q;

        case (state_q)
            ST_IDLE: begin
                if (tick_idex) begin
                    pc_d    = pc;
                    imm_d   = imm;
                    rs1_d   = rs1;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A new instruction supersedes the one still settling.
                if (tick_idex) begin
                    pc_d  = pc;
                    imm_d = imm;
                    rs1_d = rs1;
                    cnt_d = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_RESOLVE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESOLVE: begin
                state_d = ST_IDLE;
                if (reserved) begin
                    perr_d = 1'b1;
                end else if (taken) begin
                    if (misalign) begin
                        mis_d   = 1'b1;
                        maddr_d = target;
                    end else begin
                        valid_d = 1'b1;
                        rpc_d   = target;
                        flush_d = 1'b1;
                        state_d = ST_REDIRECT;
                    end
                end
            end
            ST_REDIRECT: begin
                if (tick_idex) begin
                    perr_d = 1'b1;
                end
                if (redir.redirect_ack) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pc_q    <= '0;
            imm_q   <= '0;
            rs1_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            rpc_q   <= '0;
            flush_q <= 1'b0;
            mis_q   <= 1'b0;
            maddr_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            imm_q   <= imm_d;
            rs1_q   <= rs1_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            rpc_q   <= rpc_d;
            flush_q <= flush_d;
            mis_q   <= mis_d;
            maddr_q <= maddr_d;
            perr_q  <= perr_d;
        end
    end

    assign busy                 = busy_q;
    assign flush                = flush_q;
    assign misalign_exc         = mis_q;
    assign misalign_addr        = maddr_q;
    assign proto_err            = perr_q;
    assign dbg_state_o          = state_q;
    assign redir.redirect_valid = valid_q;
    assign redir.redirect_pc    = rpc_q;
endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;
    import cpu_pkg::*;

    localparam int S = 3;
    localparam int K_NONE  = 0;
    localparam int K_REDIR = 1;
    localparam int K_MIS   = 2;
    localparam int K_PROTO = 3;

    typedef struct {
        int          kind;
        logic [31:0] tgt;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_idex = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] imm = '0;
    logic [31:0] rs1 = '0;
    logic [2:0]  branch_taken = '0;
    logic        busy, flush, misalign_exc, proto_err;
    logic [31:0] misalign_addr;
    logic [1:0]  dbg_state;

    branch_resolver_if #(.XLEN(32)) rif ();

    int compared = 0;
    int mismatched = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_maddr = '0;
    logic        exp_perr = 1'b0;

    // clock / reset
    always #5 clk = ~clk;

    branch_resolver #(.XLEN(32), .SETTLE_CYCLES(S)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tick_idex     (tick_idex),
        .pc            (pc),
        .imm           (imm),
        .rs1           (rs1),
        .branch_taken  (branch_taken),
        .busy          (busy),
        .flush         (flush),
        .misalign_exc  (misalign_exc),
        .misalign_addr (misalign_addr),
        .proto_err     (proto_err),
        .dbg_state_o   (dbg_state),
        .redir         (rif.master)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: straight from the resolution rules, 33-bit sum reduced mod 2^32.
    function automatic res_t model(input logic [2:0] code, input logic [31:0] p,
                                   input logic [31:0] i, input logic [31:0] r);
        res_t res;
        longint unsigned a, b, s;
        res.tgt = '0;
        if (code >= 3'd4) begin
            res.kind = K_PROTO;
        end else if (code == 3'd0) begin
            res.kind = K_NONE;
        end else begin
            a = (code == 3'd3) ? longint'(r) : longint'(p);
            b = longint'(i);
            s = (a + b) % 64'h1_0000_0000;
            if (code == 3'd3) s = s - (s % 2);
            res.tgt  = s[31:0];
            res.kind = (((s / 2) % 2) == 1) ? K_MIS : K_REDIR;
        end
        return res;
    endfunction

    // driver: called #1 after an edge, returns #1 after the edge that samples the tick
    task automatic issue(input logic [31:0] p, input logic [31:0] i, input logic [31:0] r,
                         input logic [2:0] code);
        pc = p; imm = i; rs1 = r; branch_taken = code; tick_idex = 1'b1;
        @(posedge clk); #1;
        tick_idex = 1'b0;
    endtask

    task automatic run_txn(input string tag, input logic [2:0] code, input logic [31:0] p,
                           input logic [31:0] i, input logic [31:0] r,
                           input int ack_delay, input bit poke);
        res_t        m;
        logic [31:0] exp_pc;
        m = model(code, p, i, r);
        issue(p, i, r, code);
        check({tag, ".busy_rise"}, 32'(busy), 32'd1);
        for (int k = 1; k <= S; k++) begin
            @(posedge clk); #1;
            check({tag, ".early_flush"}, 32'(flush), 32'd0);
            check({tag, ".early_valid"}, 32'(rif.redirect_valid), 32'd0);
        end
        @(posedge clk); #1;
        if (m.kind == K_PROTO) exp_perr = 1'b1;
        if (m.kind == K_MIS) exp_maddr = m.tgt;
        check({tag, ".flush"}, 32'(flush), 32'(m.kind == K_REDIR));
        check({tag, ".valid"}, 32'(rif.redirect_valid), 32'(m.kind == K_REDIR));
        check({tag, ".mis_exc"}, 32'(misalign_exc), 32'(m.kind == K_MIS));
        check({tag, ".mis_addr"}, misalign_addr, exp_maddr);
        check({tag, ".proto"}, 32'(proto_err), 32'(exp_perr));
        check({tag, ".busy"}, 32'(busy), 32'(m.kind == K_REDIR));
        if (m.kind == K_REDIR) begin
            exp_q.push_back(m.tgt);
            exp_pc = exp_q.pop_front();
            check({tag, ".rpc"}, rif.redirect_pc, exp_pc);
            if (poke) begin
                pc = ~p; tick_idex = 1'b1;
                @(posedge clk); #1;
                tick_idex = 1'b0;
                exp_perr = 1'b1;
                check({tag, ".poke_proto"}, 32'(proto_err), 32'(exp_perr));
                check({tag, ".poke_rpc"}, rif.redirect_pc, exp_pc);
                check({tag, ".poke_valid"}, 32'(rif.redirect_valid), 32'd1);
            end
            for (int k = 0; k < ack_delay; k++) begin
                @(posedge clk); #1;
                check({tag, ".hold_valid"}, 32'(rif.redirect_valid), 32'd1);
                check({tag, ".hold_rpc"}, rif.redirect_pc, exp_pc);
                check({tag, ".flush_pulse"}, 32'(flush), 32'd0);
            end
            rif.redirect_ack = 1'b1;
            @(posedge clk); #1;
            rif.redirect_ack = 1'b0;
            check({tag, ".ack_valid"}, 32'(rif.redirect_valid), 32'd0);
            check({tag, ".ack_busy"}, 32'(busy), 32'd0);
            check({tag, ".ack_flush"}, 32'(flush), 32'd0);
            check({tag, ".ack_idle"}, 32'(dbg_state), 32'(ST_IDLE));
        end else begin
            check({tag, ".idle"}, 32'(dbg_state), 32'(ST_IDLE));
            @(posedge clk); #1;
            check({tag, ".mis_pulse"}, 32'(misalign_exc), 32'd0);
            check({tag, ".proto_hold"}, 32'(proto_err), 32'(exp_perr));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".flush"}, 32'(flush), 32'd0);
        check({tag, ".valid"}, 32'(rif.redirect_valid), 32'd0);
        check({tag, ".rpc"}, rif.redirect_pc, 32'd0);
        check({tag, ".mis_exc"}, 32'(misalign_exc), 32'd0);
        check({tag, ".mis_addr"}, misalign_addr, 32'd0);
        check({tag, ".proto"}, 32'(proto_err), 32'd0);
        check({tag, ".state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    initial begin
        logic [2:0]  code;
        logic [31:0] rp, ri, rr;

        rif.redirect_ack = 1'b0;
        // reset
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("por.busy_after", 32'(busy), 32'd0);

        // directed cases
        run_txn("beq",       3'd1, 32'h100,  32'h20, 32'h0,    2, 1'b0);
        run_txn("jalr",      3'd3, 32'h0,    32'h4,  32'h2001, 0, 1'b0);
        run_txn("jal_mis",   3'd2, 32'h1000, 32'h6,  32'h0,    0, 1'b0);
        run_txn("not_taken", 3'd0, 32'h200,  32'h40, 32'h0,    0, 1'b0);
        run_txn("reserved",  3'd5, 32'h300,  32'h8,  32'h0,    0, 1'b0);
        run_txn("sticky",    3'd1, 32'h400,  32'h10, 32'h0,    1, 1'b0);

        // supersede in WAIT with wrap-around target
        issue(32'h500, 32'h4, 32'h0, 3'd1);
        run_txn("supersede", 3'd1, 32'hFFFF_FFF0, 32'h20, 32'h0, 1, 1'b0);

        // tick during REDIRECT
        run_txn("redir_tick", 3'd2, 32'h800, 32'h100, 32'h0, 1, 1'b1);

        // randomized transactions
        for (int n = 0; n < 40; n++) begin
            code = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) code = 3'($urandom_range(1, 3));
            rp = $urandom & 32'hFFFF_FFFC;
            ri = 32'($urandom_range(0, 63)) << 1;
            if ($urandom_range(0, 3) == 0) ri = $urandom;
            rr = $urandom;
            run_txn("rand", code, rp, ri, rr, int'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0));
        end

        // reset mid-WAIT clears sticky and held outputs within the cycle
        issue(32'h600, 32'h6, 32'h0, 3'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_wait");
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_perr = 1'b0;
        exp_maddr = '0;
        @(posedge clk); #1;
        check("rst_wait.busy_after", 32'(busy), 32'd0);

        // reset mid-REDIRECT drops valid asynchronously
        issue(32'h700, 32'h10, 32'h0, 3'd1);
        repeat (S + 1) @(posedge clk);
        #1;
        check("rst_redir.valid_before", 32'(rif.redirect_valid), 32'd1);
        check("rst_redir.rpc_before", rif.redirect_pc, 32'h710);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_redir");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_redir.busy_after", 32'(busy), 32'd0);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
